// File: rtl/matmul_fetch_tiled.sv
// Tiled matmul operand fetch: streams A rows against LANES adjacent B columns
// (columns inner, rows outer) through a 2-stage address/output pipeline with valid/ready.
module matmul_fetch_tiled #(
  parameter int unsigned MUL_SIZE  = 8,
  parameter int unsigned ELEM_BITS = 8,
  parameter int unsigned LANES     = 2,
  parameter int unsigned ADDR_BITS = $clog2(MUL_SIZE),
  parameter int unsigned VEC_BITS  = MUL_SIZE * ELEM_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_BITS:0]         cfg_rows,
  input  logic [ADDR_BITS:0]         cfg_cols,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_BITS-1:0]       a_addr,
  input  logic [VEC_BITS-1:0]        a_data,
  output logic [LANES*ADDR_BITS-1:0] b_addr,
  input  logic [LANES*VEC_BITS-1:0]  b_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_BITS-1:0]       row_no,
  output logic [VEC_BITS-1:0]        row,
  output logic [ADDR_BITS-1:0]       col_no,
  output logic [LANES-1:0]           col_mask,
  output logic [LANES*VEC_BITS-1:0]  col,
  output logic                       last
);

  localparam int unsigned IW = ADDR_BITS + 1;
  localparam logic [IW-1:0] MAX_DIM = IW'(MUL_SIZE);
  localparam logic [IW-1:0] STEP    = IW'(LANES);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [IW-1:0]    rows_q, cols_q;
  logic [IW-1:0]    row_q, cb_q;
  logic             v1_q, last1_q;
  logic [LANES-1:0] mask1_q;

  logic             advance;
  logic [IW-1:0]    rows_cap, cols_cap, eff_rows, eff_cols;
  logic             load_cfg, nxt_v, nxt_last;
  logic [IW-1:0]    nxt_row, nxt_cb;
  logic             step_wrap, is_final;
  logic [LANES-1:0] nxt_mask;
  logic [LANES*ADDR_BITS-1:0] nxt_baddr;

  assign advance   = !out_valid || out_ready;
  assign rows_cap  = (cfg_rows > MAX_DIM) ? MAX_DIM : cfg_rows;
  assign cols_cap  = (cfg_cols > MAX_DIM) ? MAX_DIM : cfg_cols;
  assign eff_rows  = load_cfg ? rows_cap : rows_q;
  assign eff_cols  = load_cfg ? cols_cap : cols_q;
  assign step_wrap = (cb_q + STEP) >= cols_q;
  assign is_final  = step_wrap && (row_q == rows_q - IW'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and next issue index; an empty config drains an empty pipe for one cycle.
  always_comb begin
    state_d  = state_q;
    load_cfg = 1'b0;
    nxt_v    = v1_q;
    nxt_row  = row_q;
    nxt_cb   = cb_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_cfg = 1'b1;
          if (rows_cap == '0 || cols_cap == '0) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_FETCH;
            nxt_v   = 1'b1;
            nxt_row = '0;
            nxt_cb  = '0;
          end
        end
      end
      S_FETCH: begin
        if (advance) begin
          if (is_final) begin
            nxt_v   = 1'b0;
            state_d = S_DRAIN;
          end else begin
            nxt_v = 1'b1;
            if (step_wrap) begin
              nxt_cb  = '0;
              nxt_row = row_q + IW'(1);
            end else begin
              nxt_cb = cb_q + STEP;
            end
          end
        end
      end
      S_DRAIN: begin
        if ((out_valid && out_ready && last) || (!out_valid && !v1_q)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-lane addresses and validity for the index about to be issued.
  always_comb begin : lane_addr
    logic [IW-1:0] lane_col;
    lane_col  = '0;
    nxt_mask  = '0;
    nxt_baddr = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_col = nxt_cb + IW'(l);
      if (lane_col < eff_cols) begin
        nxt_mask[l] = 1'b1;
        nxt_baddr[l*ADDR_BITS +: ADDR_BITS] = lane_col[ADDR_BITS-1:0];
      end
    end
    nxt_last = (nxt_row == eff_rows - IW'(1)) && ((nxt_cb + STEP) >= eff_cols);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
      row_q     <= '0;
      cb_q      <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      mask1_q   <= '0;
      a_addr    <= '0;
      b_addr    <= '0;
      out_valid <= 1'b0;
      row_no    <= '0;
      row       <= '0;
      col_no    <= '0;
      col_mask  <= '0;
      col       <= '0;
      last      <= 1'b0;
    end else begin
      busy <= (state_d == S_FETCH) || (state_d == S_DRAIN);
      done <= (state_d == S_DONE);
      if (load_cfg) begin
        rows_q <= rows_cap;
        cols_q <= cols_cap;
      end
      // Both stages move together; a stall freezes addresses so memory data stays put.
      if (advance) begin
        v1_q <= nxt_v;
        if (nxt_v) begin
          row_q   <= nxt_row;
          cb_q    <= nxt_cb;
          a_addr  <= nxt_row[ADDR_BITS-1:0];
          b_addr  <= nxt_baddr;
          mask1_q <= nxt_mask;
          last1_q <= nxt_last;
        end
        out_valid <= v1_q;
        last      <= v1_q && last1_q;
        if (v1_q) begin
          row      <= a_data;
          row_no   <= row_q[ADDR_BITS-1:0];
          col_no   <= cb_q[ADDR_BITS-1:0];
          col_mask <= mask1_q;
          for (int l = 0; l < LANES; l++) begin
            col[l*VEC_BITS +: VEC_BITS] <= mask1_q[l] ? b_data[l*VEC_BITS +: VEC_BITS] : '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_matmul_fetch_tiled.sv
// Scoreboard bench for matmul_fetch_tiled: a tile-walk model fills the queue, a monitor
// pops on every handshake and also checks stall stability and done timing.
module tb_matmul_fetch_tiled;

  localparam int unsigned MUL_SIZE  = 8;
  localparam int unsigned ELEM_BITS = 8;
  localparam int unsigned LANES     = 2;
  localparam int unsigned ADDR_BITS = $clog2(MUL_SIZE);
  localparam int unsigned VEC_BITS  = MUL_SIZE * ELEM_BITS;

  typedef struct {
    int                        row_no;
    int                        col_no;
    logic [LANES-1:0]          mask;
    logic [VEC_BITS-1:0]       row;
    logic [LANES*VEC_BITS-1:0] col;
    logic                      last;
  } beat_t;

  logic                       clk;
  logic                       rst;
  logic                       start;
  logic [ADDR_BITS:0]         cfg_rows;
  logic [ADDR_BITS:0]         cfg_cols;
  logic                       busy;
  logic                       done;
  logic [ADDR_BITS-1:0]       a_addr;
  logic [VEC_BITS-1:0]        a_data;
  logic [LANES*ADDR_BITS-1:0] b_addr;
  logic [LANES*VEC_BITS-1:0]  b_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [ADDR_BITS-1:0]       row_no;
  logic [VEC_BITS-1:0]        row;
  logic [ADDR_BITS-1:0]       col_no;
  logic [LANES-1:0]           col_mask;
  logic [LANES*VEC_BITS-1:0]  col;
  logic                       last;

  logic [VEC_BITS-1:0] mem_a [MUL_SIZE];
  logic [VEC_BITS-1:0] mem_b [MUL_SIZE];

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  int    exp_done_zero = -1;
  int    exp_done_hs = -1;
  int    done_cnt = 0;
  int    rdy_mode = 0;
  int    start_cyc = 0;
  bit    chk_timing = 0;
  int    beat_idx = 0;

  matmul_fetch_tiled #(
    .MUL_SIZE(MUL_SIZE), .ELEM_BITS(ELEM_BITS), .LANES(LANES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .busy(busy), .done(done), .a_addr(a_addr), .a_data(a_data), .b_addr(b_addr),
    .b_data(b_data), .out_valid(out_valid), .out_ready(out_ready), .row_no(row_no),
    .row(row), .col_no(col_no), .col_mask(col_mask), .col(col), .last(last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand memories: read data follows the presented address.
  assign a_data = mem_a[a_addr];
  always_comb begin
    b_data = '0;
    for (int l = 0; l < LANES; l++) b_data[l*VEC_BITS +: VEC_BITS] = mem_b[b_addr[l*ADDR_BITS +: ADDR_BITS]];
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] out_snapshot();
    return 256'({out_valid, last, col_mask, row_no, col_no, row, col});
  endfunction

  task automatic monitor_loop();
    bit            prev_stall;
    logic [255:0]  snap;
    beat_t         e;
    prev_stall = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall) chk("stall_hold", out_snapshot(), snap);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 256'(1), 256'(0));
        end else begin
          e = sb.pop_front();
          chk("row_no", 256'(row_no), 256'(e.row_no));
          chk("col_no", 256'(col_no), 256'(e.col_no));
          chk("col_mask", 256'(col_mask), 256'(e.mask));
          chk("row", 256'(row), 256'(e.row));
          chk("col", 256'(col), 256'(e.col));
          chk("last", 256'(last), 256'(e.last));
          if (chk_timing) chk("beat_cycle", 256'(cyc), 256'(start_cyc + 2 + beat_idx));
          beat_idx++;
          if (e.last) exp_done_hs = cyc + 1;
        end
      end
      if (done || cyc == exp_done_hs || cyc == exp_done_zero) begin
        chk("done", 256'(done), 256'(cyc == exp_done_hs || cyc == exp_done_zero));
        if (done) done_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      snap = out_snapshot();
    end
  endtask

  task automatic ready_loop();
    int pat;
    pat = 0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          out_ready = (pat == 0 || pat == 3);
          pat = (pat + 1) % 4;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  endtask

  // Fill memories and enqueue the full walk: rows outer, LANES-wide column groups inner.
  task automatic load_model(input int r, input int c, output int rc, output int cc);
    beat_t e;
    for (int i = 0; i < MUL_SIZE; i++) begin
      mem_a[i] = {$urandom, $urandom};
      mem_b[i] = {$urandom, $urandom};
    end
    rc = (r > MUL_SIZE) ? MUL_SIZE : r;
    cc = (c > MUL_SIZE) ? MUL_SIZE : c;
    for (int rr = 0; rr < rc; rr++) begin
      for (int cb = 0; cb < cc; cb += LANES) begin
        e.row_no = rr;
        e.col_no = cb;
        e.row    = mem_a[rr];
        e.mask   = '0;
        e.col    = '0;
        e.last   = 1'b0;
        for (int l = 0; l < LANES; l++) begin
          if (cb + l < cc) begin
            e.mask[l] = 1'b1;
            e.col[l*VEC_BITS +: VEC_BITS] = mem_b[cb + l];
          end
        end
        sb.push_back(e);
      end
    end
    if (sb.size() > 0) sb[sb.size()-1].last = 1'b1;
  endtask

  task automatic run_op(input int r, input int c, input int mode, input bit timing, input bit spur);
    int rc, cc, d0, waited;
    load_model(r, c, rc, cc);
    @(posedge clk);
    #1;
    rdy_mode   = mode;
    cfg_rows   = (ADDR_BITS+1)'(r);
    cfg_cols   = (ADDR_BITS+1)'(c);
    start      = 1'b1;
    start_cyc  = cyc;
    chk_timing = timing;
    beat_idx   = 0;
    if (rc == 0 || cc == 0) exp_done_zero = cyc + 2;
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (rc != 0 && cc != 0) chk("busy_after_start", 256'(busy), 256'(1));
    waited = 0;
    while (done_cnt == d0 && waited < 400) begin
      // A start while busy must be ignored.
      if (spur && waited == 3) begin
        start    = 1'b1;
        cfg_rows = 1;
        cfg_cols = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    start = 1'b0;
    chk("done_seen", 256'(done_cnt != d0), 256'(1));
    chk("sb_empty", 256'(sb.size()), 256'(0));
    sb.delete();
  endtask

  task automatic run_reset_mid();
    int rc, cc, waited;
    load_model(8, 8, rc, cc);
    @(posedge clk);
    #1;
    rdy_mode   = 0;
    cfg_rows   = 8;
    cfg_cols   = 8;
    start      = 1'b1;
    chk_timing = 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    waited = 0;
    while (!(out_valid && row_no == 0 && col_no == 4) && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    chk("beat3_reached", 256'(waited < 50), 256'(1));
    rst = 1'b1;
    rdy_mode = 3;
    sb.delete();
    @(posedge clk);
    #1;
    chk("midrst_outputs", 256'({busy, done, out_valid, last, a_addr, b_addr, col_mask, row_no, col_no, row, col}), 256'(0));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_idle", 256'({busy, out_valid}), 256'(0));
    rdy_mode = 0;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_rows = '0;
    cfg_cols = '0;
    out_ready = 1'b1;
    for (int i = 0; i < MUL_SIZE; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    fork
      monitor_loop();
      ready_loop();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 256'({busy, done, out_valid, last, a_addr, b_addr, col_mask, row_no, col_no, row, col}), 256'(0));
    rst = 1'b0;

    run_op(3, 5, 0, 1, 0);
    run_op(8, 8, 0, 1, 1);
    run_op(2, 4, 1, 0, 0);
    run_op(0, 5, 0, 0, 0);
    run_op(9, 9, 0, 1, 0);
    run_reset_mid();
    run_op(8, 8, 0, 1, 0);
    for (int k = 0; k < 8; k++) begin
      run_op(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), 2, 0, 0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
